load_store_unit: RTL and testbench

Data-memory access stage sitting directly downstream of the address generator. It captures a load or store request (opcode, funct3, effective address, store data), drives a single-outstanding request/acknowledge data bus with word-aligned address and byte-lane mask, and returns sign- or zero-extended load data. It also stalls the pipeline while the access is in flight.

---
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store stage: latches one request, runs a req/ack data bus, returns extended load data.
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses into two bus transfers.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // state   | meaning
  // IDLE    | waiting for a load/store request
  // ACCESS0 | first (or only) bus transfer in flight
  // ACCESS1 | second transfer of a word-crossing access
  // RESP    | one-cycle done/error pulse
  typedef enum logic [1:0] {IDLE, ACCESS0, ACCESS1, RESP} state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t state, state_nxt;

  logic        err_q, split_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] sd_q, first_q;

  logic        is_load, is_store, accept, legal, split_in, f3_ok, ack_ok;
  logic [2:0]  size_in;
  logic [3:0]  mask_lo_in, mask_hi_q;
  logic [31:0] wdata_lo_in, wdata_hi_q, shifted, ext_data;
  logic [63:0] rd64;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  always_comb begin
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    accept   = valid && (is_load || is_store);
    case (funct3[1:0])
      2'b00:   size_in = 3'd1;
      2'b01:   size_in = 3'd2;
      default: size_in = 3'd4;
    endcase
    if (is_load)
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    else
      f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
`ifdef MISALIGNED_SPLIT_EN
    split_in = (({1'b0, address[1:0]} + size_in) > 3'd4);
    legal    = f3_ok;
`else
    split_in = 1'b0;
    legal    = f3_ok && !(((size_in == 3'd2) && address[0]) ||
                          ((size_in == 3'd4) && (address[1:0] != 2'b00)));
`endif
    mask_lo_in  = 4'({4'b0000, size_mask(funct3[1:0])} << address[1:0]);
    wdata_lo_in = store_data << {address[1:0], 3'b000};
    // Lanes spilling past byte 3 become the second transfer's lanes, starting at lane 0.
    mask_hi_q   = 4'(({4'b0000, size_mask(f3_q[1:0])} << off_q) >> 4);
    wdata_hi_q  = 32'(({32'd0, sd_q} << {off_q, 3'b000}) >> 32);
  end

  always_comb begin
    ack_ok  = mem_req && mem_ack;
    rd64    = (state == ACCESS1) ? {mem_rdata, first_q} : {32'd0, mem_rdata};
    shifted = 32'(rd64 >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext_data = {24'd0, shifted[7:0]};
      3'b101:  ext_data = {16'd0, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = legal ? ACCESS0 : RESP;
      ACCESS0: if (ack_ok) state_nxt = split_q ? ACCESS1 : RESP;
      ACCESS1: if (ack_ok) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    done  = (state == RESP) && !err_q;
    error = (state == RESP) && err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q     <= 1'b0;
      split_q   <= 1'b0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      sd_q      <= 32'd0;
      first_q   <= 32'd0;
      load_data <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wmask <= 4'b0000;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          err_q   <= !legal;
          split_q <= split_in;
          off_q   <= address[1:0];
          f3_q    <= funct3;
          sd_q    <= store_data;
          if (legal) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {address[31:2], 2'b00};
            mem_wmask <= mask_lo_in;
            mem_wdata <= wdata_lo_in;
          end
        end
        ACCESS0: if (ack_ok) begin
          first_q <= mem_rdata;
          if (split_q) begin
            mem_addr  <= mem_addr + 32'd4;
            mem_wmask <= mask_hi_q;
            mem_wdata <= wdata_hi_q;
          end else begin
            mem_req <= 1'b0;
            if (!mem_we) load_data <= ext_data;
          end
        end
        ACCESS1: if (ack_ok) begin
          mem_req <= 1'b0;
          if (!mem_we) load_data <= ext_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; expectations follow the MISALIGNED_SPLIT_EN build setting.
module tb_load_store_unit;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_AL = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset, valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] address, store_data;
  logic        busy, done, error;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clk(clk), .reset(reset), .valid(valid), .opcode(opcode), .funct3(funct3),
    .address(address), .store_data(store_data), .busy(busy), .done(done),
    .error(error), .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          res_lat, n_xfer;
  logic        res_done, res_err, req_seen, stable_ok;
  logic [31:0] xa[2], xd[2];
  logic [3:0]  xm[2];
  logic        xwe[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, plays the bus with 'waits' stall cycles per transfer,
  // records each transfer and the cycle offset of done/error, then returns to IDLE.
  task automatic run_req(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input int waits, input logic pulse,
                         input logic [31:0] rd0, input logic [31:0] rd1);
    int   cyc, wcnt;
    logic acked, saw_req;
    res_lat = -1; res_done = 0; res_err = 0; req_seen = 0; stable_ok = 1; n_xfer = 0;
    valid = 1; opcode = op; funct3 = f3; address = addr; store_data = sd;
    tick();
    valid = 0;
    cyc = 1; wcnt = 0; acked = 0;
    while (cyc < 20) begin
      valid = 0;
      if (done || error) begin
        res_lat = cyc; res_done = done; res_err = error;
        break;
      end
      saw_req = mem_req;
      if (mem_req) begin
        req_seen = 1;
        if (n_xfer < 2) begin
          if (wcnt == 0) begin
            xa[n_xfer] = mem_addr; xm[n_xfer] = mem_wmask;
            xd[n_xfer] = mem_wdata; xwe[n_xfer] = mem_we;
          end else if (mem_addr !== xa[n_xfer] || mem_wmask !== xm[n_xfer] ||
                       mem_wdata !== xd[n_xfer] || mem_we !== xwe[n_xfer]) begin
            stable_ok = 0;
          end
        end
        if (wcnt == waits) begin
          mem_ack = 1; mem_rdata = (n_xfer == 0) ? rd0 : rd1; acked = 1;
        end else begin
          mem_ack = 0;
          if (pulse && wcnt == 1) begin
            valid = 1; opcode = OP_LD; funct3 = 3'b010; address = 32'h700;
          end
        end
      end
      tick();
      if (acked) begin
        n_xfer++; wcnt = 0; mem_ack = 0; acked = 0;
      end else if (saw_req) begin
        wcnt++;
      end
      cyc++;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 0; valid = 0; opcode = 0; funct3 = 0; address = 0; store_data = 0;
    mem_ack = 0; mem_rdata = 0;
    tick(); tick();
    check_val("rst_busy", busy, 0);
    check_val("rst_done_err", {done, error}, 0);
    check_val("rst_req_we", {mem_req, mem_we}, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wmask", mem_wmask, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_val("rst_load_data", load_data, 0);
    reset = 1;
    tick();

    run_req(OP_LD, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF, 0);
    check_val("lw_lat", res_lat, 2);
    check_val("lw_done", {res_done, res_err}, 2'b10);
    check_val("lw_addr", xa[0], 32'h100);
    check_val("lw_we", xwe[0], 0);
    check_val("lw_mask", xm[0], 4'b1111);
    check_val("lw_xfers", n_xfer, 1);
    check_val("lw_data", load_data, 32'hDEADBEEF);

    run_req(OP_LD, 3'b000, 32'h203, 0, 0, 0, 32'h80112233, 0);
    check_val("lb_addr", xa[0], 32'h200);
    check_val("lb_mask", xm[0], 4'b1000);
    check_val("lb_data", load_data, 32'hFFFFFF80);
    tick();
    check_val("lb_hold", load_data, 32'hFFFFFF80);
    run_req(OP_LD, 3'b100, 32'h203, 0, 0, 0, 32'h80112233, 0);
    check_val("lbu_data", load_data, 32'h00000080);
    run_req(OP_LD, 3'b001, 32'h202, 0, 0, 0, 32'h80112233, 0);
    check_val("lh_data", load_data, 32'hFFFF8011);
    run_req(OP_LD, 3'b101, 32'h202, 0, 0, 0, 32'h80112233, 0);
    check_val("lhu_data", load_data, 32'h00008011);

    run_req(OP_ST, 3'b001, 32'h302, 32'h0000ABCD, 0, 0, 0, 0);
    check_val("sh_addr", xa[0], 32'h300);
    check_val("sh_mask", xm[0], 4'b1100);
    check_val("sh_wdata", xd[0], 32'hABCD0000);
    check_val("sh_we", xwe[0], 1);
    check_val("sh_lat", res_lat, 2);

    run_req(OP_ST, 3'b000, 32'h101, 32'h12345678, 0, 0, 0, 0);
    check_val("sb_mask", xm[0], 4'b0010);
    check_val("sb_wdata", xd[0], 32'h34567800);

    run_req(OP_LD, 3'b010, 32'h0FE, 0, 0, 0, 32'h11223344, 32'h55667788);
`ifdef MISALIGNED_SPLIT_EN
    check_val("split_lw_lat", res_lat, 3);
    check_val("split_lw_xfers", n_xfer, 2);
    check_val("split_lw_addr0", xa[0], 32'h0FC);
    check_val("split_lw_addr1", xa[1], 32'h100);
    check_val("split_lw_mask0", xm[0], 4'b1100);
    check_val("split_lw_mask1", xm[1], 4'b0011);
    check_val("split_lw_data", load_data, 32'h77881122);
`else
    check_val("mis_lw_lat", res_lat, 1);
    check_val("mis_lw_err", {res_done, res_err}, 2'b01);
    check_val("mis_lw_noreq", req_seen, 0);
`endif

    run_req(OP_LD, 3'b001, 32'h101, 0, 0, 0, 32'h11223344, 0);
`ifdef MISALIGNED_SPLIT_EN
    check_val("inword_lh_xfers", n_xfer, 1);
    check_val("inword_lh_mask", xm[0], 4'b0110);
    check_val("inword_lh_data", load_data, 32'h00002233);
`else
    check_val("mis_lh_err", {res_done, res_err}, 2'b01);
    check_val("mis_lh_noreq", req_seen, 0);
`endif

    run_req(OP_ST, 3'b010, 32'hFFFFFFFD, 32'hAABBCCDD, 0, 0, 0, 0);
`ifdef MISALIGNED_SPLIT_EN
    check_val("wrap_sw_lat", res_lat, 3);
    check_val("wrap_sw_addr0", xa[0], 32'hFFFFFFFC);
    check_val("wrap_sw_addr1", xa[1], 32'h00000000);
    check_val("wrap_sw_mask", {xm[0], xm[1]}, 8'b1110_0001);
    check_val("wrap_sw_wdata0", xd[0], 32'hBBCCDD00);
    check_val("wrap_sw_wdata1", xd[1], 32'h000000AA);
`else
    check_val("mis_sw_err", {res_done, res_err}, 2'b01);
`endif

    run_req(OP_LD, 3'b011, 32'h800, 0, 0, 0, 0, 0);
    check_val("bad_ld_f3", {res_done, res_err, req_seen}, 3'b010);
    check_val("bad_ld_lat", res_lat, 1);
    run_req(OP_ST, 3'b100, 32'h800, 0, 0, 0, 0, 0);
    check_val("bad_st_f3", {res_done, res_err, req_seen}, 3'b010);

    valid = 1; opcode = OP_AL; funct3 = 0; address = 32'h900;
    tick();
    valid = 0;
    check_val("ignored_opcode", {busy, mem_req}, 0);

    run_req(OP_ST, 3'b010, 32'h400, 32'h0BADF00D, 3, 1, 0, 0);
    check_val("sw_wait_lat", res_lat, 5);
    check_val("sw_wait_stable", stable_ok, 1);
    check_val("sw_wait_xfer", {xa[0], xm[0]}, {32'h400, 4'b1111});
    check_val("sw_wait_wdata", xd[0], 32'h0BADF00D);
    check_val("sw_stalled_valid", busy, 0);

    valid = 1; opcode = OP_LD; funct3 = 3'b010; address = 32'h500;
    tick();
    valid = 0;
    check_val("rst_mid_req_up", mem_req, 1);
    tick();
    #2 reset = 0;
    #1;
    check_val("rst_mid_drop", {mem_req, busy, done}, 0);
    #3 reset = 1;
    tick();
    run_req(OP_LD, 3'b010, 32'h600, 0, 0, 0, 32'hCAFEF00D, 0);
    check_val("post_rst_lat", res_lat, 2);
    check_val("post_rst_data", load_data, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
